// File: rtl/spi_clock_divider.sv
// spi_clock_divider: divides i_clk by a runtime divisor and emits BURST_LEN o_clk periods per start
module spi_clock_divider #(
  parameter int DIV_WIDTH = 8,
  parameter int BURST_LEN = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DIV_WIDTH:0]   i_config,
  input  logic                 i_start_n,
  output logic                 o_ready,
  output logic                 o_clk
);
  localparam int PW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div, r_d, r_cnt;
  logic [PW-1:0]        r_per;
  logic [DIV_WIDTH-1:0] w_lo, w_nxt;
  logic                 w_wrap, w_last;
  assign w_lo   = r_d - (r_d >> 1);
  assign w_wrap = r_cnt == r_d - DIV_WIDTH'(1);
  assign w_nxt  = w_wrap ? '0 : r_cnt + DIV_WIDTH'(1);
  assign w_last = w_wrap && r_per == PW'(BURST_LEN - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_div   <= DIV_WIDTH'(2);
      r_d     <= DIV_WIDTH'(2);
      r_cnt   <= '0;
      r_per   <= '0;
      o_ready <= 1'b1;
      o_clk   <= 1'b0;
    end else begin
      if (i_config[0]) r_div <= i_config[DIV_WIDTH:1];
      case (r_state)
        IDLE: if (!i_start_n) begin
          r_state <= RUN;
          r_d     <= (r_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : r_div;
          r_cnt   <= '0;
          r_per   <= '0;
          o_ready <= 1'b0;
          o_clk   <= 1'b0;
        end
        RUN: begin
          r_cnt   <= w_nxt;
          r_per   <= w_wrap ? r_per + PW'(1) : r_per;
          o_clk   <= !w_last && (w_nxt >= w_lo);
          r_state <= w_last ? DONE : RUN;
        end
        DONE: begin
          r_state <= IDLE;
          o_ready <= 1'b1;
          o_clk   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_clock_divider.sv
// tb_spi_clock_divider: table-driven bursts plus corner-case sequences for spi_clock_divider
module tb_spi_clock_divider;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] cfg_in = '0;
  logic       start_n = 1'b1;
  logic       ready, sclk;
  int         total = 0;
  int         bad = 0;
  typedef struct {int cfg; int busy; int lo; int hi; int rises;} vec_t;
  vec_t tbl[8];
  spi_clock_divider dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_config(cfg_in),
    .i_start_n(start_n), .o_ready(ready), .o_clk(sclk)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic write_cfg(input int v);
    @(negedge clk) cfg_in = {8'(v), 1'b1};
    @(negedge clk) cfg_in = '0;
  endtask
  task automatic pulse_start;
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
  endtask
  // Samples the current negedge first, then one sample per cycle until o_ready returns.
  task automatic measure(input int lo, input int hi, input int cfg_at, input int cfg_val,
                         output int busy, output int errs, output int rises);
    int p;
    logic prev, e;
    busy = 0; errs = 0; rises = 0; prev = 1'b0; p = lo + hi;
    while (!ready && busy < 5000) begin
      e = (busy < 8 * p) ? ((busy % p) >= lo) : 1'b0;
      if (sclk !== e) errs++;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (busy == cfg_at) cfg_in = {8'(cfg_val), 1'b1};
      else if (busy == cfg_at + 1) cfg_in = '0;
      busy++;
      @(negedge clk);
    end
  endtask
  task automatic run_check(input string tag, input int lo, input int hi, input int exp_busy,
                           input int cfg_at, input int cfg_val);
    int b, e, r;
    measure(lo, hi, cfg_at, cfg_val, b, e, r);
    chk({tag, "_busy"}, b, exp_busy);
    chk({tag, "_pattern_errs"}, e, 0);
    chk({tag, "_rises"}, r, 8);
    chk({tag, "_end_ready"}, int'(ready), 1);
    chk({tag, "_end_clk"}, int'(sclk), 0);
  endtask
  initial begin
    tbl[0] = '{250, 2001, 125, 125, 8};
    tbl[1] = '{100, 801, 50, 50, 8};
    tbl[2] = '{4, 33, 2, 2, 8};
    tbl[3] = '{2, 17, 1, 1, 8};
    tbl[4] = '{0, 17, 1, 1, 8};
    tbl[5] = '{1, 17, 1, 1, 8};
    tbl[6] = '{5, 41, 3, 2, 8};
    tbl[7] = '{3, 25, 2, 1, 8};
    repeat (16) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    chk("reset_ready", int'(ready), 1);
    chk("reset_clk", int'(sclk), 0);
    for (int i = 0; i < 8; i++) begin
      write_cfg(tbl[i].cfg);
      pulse_start();
      run_check($sformatf("vec%0d_d%0d", i, tbl[i].cfg), tbl[i].lo, tbl[i].hi, tbl[i].busy, -1, 0);
    end
    write_cfg(4);
    pulse_start();
    run_check("midcfg_keep4", 2, 2, 33, 5, 2);
    pulse_start();
    run_check("midcfg_next2", 1, 1, 17, -1, 0);
    write_cfg(2);
    @(negedge clk) start_n = 1'b0;
    @(negedge clk);
    run_check("b2b_first", 1, 1, 17, -1, 0);
    @(negedge clk);
    chk("b2b_restart_ready", int'(ready), 0);
    start_n = 1'b1;
    run_check("b2b_second", 1, 1, 17, -1, 0);
    write_cfg(4);
    pulse_start();
    repeat (10) @(negedge clk);
    chk("async_pre_clk", int'(sclk), 1);
    chk("async_pre_ready", int'(ready), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_clk", int'(sclk), 0);
    chk("async_rst_ready", int'(ready), 1);
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    run_check("post_rst_d2", 1, 1, 17, -1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
